aes_load_interface: RTL and testbench
=====================================

AES_LOAD_INTERFACE -- requirements
Module: aes_load_interface

Interface
REQ-001 The block SHALL have parameter DIN_W, default 8, meaning serial input beat width in bits; legal values are 8, 16 and 32.
REQ-002 The block SHALL have parameter KEY_W, default 128, meaning key width in bits; legal values are 128, 192 and 256.
REQ-003 The block SHALL have parameter KEEP_KEY, default 0, meaning that when 1 the key and its loaded flag survive engine_done.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port din, input, width DIN_W: the serial data beat.
REQ-007 The block SHALL have port cmd, input, width 2: 00 no-op, 01 load plaintext, 10 load key, 11 start.
REQ-008 The block SHALL have port cmd_valid, input, width 1: cmd/din qualifier.
REQ-009 The block SHALL have port ready, output, width 1: block accepts a beat this cycle.
REQ-010 The block SHALL have port engine_done, input, width 1: single-cycle completion pulse from the engine.
REQ-011 The block SHALL have port engine_start, output, width 1: registered single-cycle start pulse.
REQ-012 The block SHALL have port plain_out, output, width 128: the plaintext register.
REQ-013 The block SHALL have port key_out, output, width KEY_W: the key register.
REQ-014 The block SHALL have port err, output, width 1: registered single-cycle protocol-error pulse.
REQ-015 The block SHALL have port loaded, output, width 2: {key_loaded, plain_loaded} flags.

Function
REQ-016 The block SHALL be a four-state FSM: IDLE, LOAD_P, LOAD_K and RUN.
REQ-017 A beat SHALL be accepted only when cmd_valid && ready.
REQ-018 ready SHALL be 1 in IDLE, LOAD_P and LOAD_K, and 0 in RUN.
REQ-019 Beat counts SHALL be fixed: P_BEATS = 128/DIN_W and K_BEATS = KEY_W/DIN_W; the beat counter is sized to clog2 of the larger count.
REQ-020 In IDLE, an accepted cmd 01 SHALL:
- clear plain_loaded;
- load plain <= {120'b0-equivalent zeros, din}, i.e. the register cleared then din shifted in;
- set the counter to 1;
- go to LOAD_P.
REQ-021 If P_BEATS == 1 were possible it would complete immediately; with the legal parameter set it never is.
REQ-022 In LOAD_P, each accepted cmd 01 beat SHALL:
- shift plain <= {plain[127-DIN_W:0], din}, so the first beat ends in the MSBs;
- increment the counter.
REQ-023 The beat that makes the count P_BEATS SHALL set plain_loaded and return to IDLE in the same edge.
REQ-024 cmd 10 SHALL behave identically on key, key_loaded, LOAD_K and K_BEATS.
REQ-025 Cycles without an accepted beat SHALL hold all state; there is no timeout.
REQ-026 An accepted beat whose cmd differs from the active load (in LOAD_P or LOAD_K) SHALL abort the load:
- target register cleared to 0;
- its flag cleared;
- counter cleared;
- err pulsed;
- return to IDLE;
- the offending beat discarded.
REQ-027 In IDLE, an accepted cmd 11 with both flags set SHALL enter RUN and pulse engine_start on the next cycle, exactly once.
REQ-028 In IDLE, an accepted cmd 11 with either flag clear SHALL pulse err and stay in IDLE.
REQ-029 In IDLE, cmd 00 SHALL be a no-op.
REQ-030 plain_out and key_out SHALL remain stable throughout RUN.
REQ-031 engine_done in RUN SHALL:
- clear plain and plain_loaded;
- if KEEP_KEY == 0, also clear key and key_loaded;
- return to IDLE.
REQ-032 engine_done outside RUN SHALL be ignored.
REQ-033 engine_done arriving in the same cycle engine_start is high SHALL be honoured.
REQ-034 err and engine_start SHALL never both be high in the same cycle.

Reset
REQ-035 On rst_ low, asynchronously:
- state SHALL be IDLE;
- plain, key, counter, loaded, engine_start and err SHALL be 0;
- ready SHALL be 1 once state is IDLE.
REQ-036 Reset asserted mid-load or in RUN SHALL discard all partial data; no engine_start pulse follows reset release.
REQ-037 Reset release SHALL be synchronised by the integrator; the block makes no deassertion-timing assumption beyond clk.

Verification
REQ-038 Scenario (DIN_W=8, KEY_W=128): 16 plain beats 0x00..0x0F, then 16 key beats 0xF0..0xFF, then cmd 11 -> plain_out = 0x000102..0F; key_out = 0xF0F1..FF; engine_start high exactly one cycle, one cycle after the start beat; ready=0 until engine_done.
REQ-039 Scenario (DIN_W=32, KEY_W=256): 8 key beats 0x11111111..0x88888888 -> key_loaded after the 8th beat; key_out = 0x11111111_22222222_..._88888888.
REQ-040 Scenario: 5 plain beats, then a key beat -> err pulse; plain_out=0; loaded=00; state IDLE; the key beat is not stored.
REQ-041 Scenario: cmd 11 with only the key loaded -> err pulse; no engine_start; loaded=10 unchanged.
REQ-042 Scenario (KEEP_KEY=1): full load, start, engine_done -> loaded=10 and key_out retained; a new 16-beat plaintext load followed by cmd 11 restarts without reloading the key.
REQ-043 Scenario: rst_ pulsed low asynchronously between clock edges in the middle of a key load -> all outputs zero immediately; after release, a full key load completes normally.

Source files
------------

// File: rtl/aes_load_interface_if.sv
// Serial load bus between a command source and aes_load_interface.
// The source drives a command/data beat with a valid qualifier; the loader
// answers with ready, and a beat moves only when valid and ready are both high.
interface aes_load_interface_if #(
  parameter int DIN_W = 8
) ();

  logic [DIN_W-1:0] din;
  logic [1:0]       cmd;
  logic             cmd_valid;
  logic             ready;

  modport master (
    output din,
    output cmd,
    output cmd_valid,
    input  ready
  );

  modport slave (
    input  din,
    input  cmd,
    input  cmd_valid,
    output ready
  );

endinterface

// File: rtl/aes_load_interface.sv
// Serial loader for an AES engine: assembles a 128-bit plaintext and a
// KEY_W-bit key from DIN_W-bit beats, tracks which of the two is complete,
// and issues a one-cycle start pulse to the engine once both are present.
// A beat whose command conflicts with an active load aborts that load.
module aes_load_interface #(
  parameter int DIN_W    = 8,    // beat width: 8, 16 or 32
  parameter int KEY_W    = 128,  // key width: 128, 192 or 256
  parameter int KEEP_KEY = 0     // 1: key and key_loaded survive engine_done
) (
  input  logic                clk,
  input  logic                rst_,
  aes_load_interface_if.slave bus,
  input  logic                engine_done,
  output logic                engine_start,
  output logic [127:0]        plain_out,
  output logic [KEY_W-1:0]    key_out,
  output logic                err,
  output logic [1:0]          loaded
);

  localparam int P_BEATS   = 128 / DIN_W;
  localparam int K_BEATS   = KEY_W / DIN_W;
  localparam int MAX_BEATS = (P_BEATS > K_BEATS) ? P_BEATS : K_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS);

  // The counter holds the number of beats already taken, so a load is
  // complete when the beat arriving finds the counter one short of the total.
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P_BEATS - 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_P = 2'd1,
    LOAD_K = 2'd2,
    RUN    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_PLAIN = 2'b01,
    CMD_KEY   = 2'b10,
    CMD_START = 2'b11
  } cmd_e;

  state_e           state_q, state_d;
  logic [127:0]     plain_q, plain_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             plain_ld_q, plain_ld_d;
  logic             key_ld_q, key_ld_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             ready;
  logic             accept;
  cmd_e             cmd;

  assign cmd    = cmd_e'(bus.cmd);
  assign ready  = (state_q != RUN);
  assign accept = bus.cmd_valid && ready;

  // Register bank: FSM state, data registers, flags and the output pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      plain_q    <= '0;
      key_q      <= '0;
      cnt_q      <= '0;
      plain_ld_q <= 1'b0;
      key_ld_q   <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      plain_q    <= plain_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      plain_ld_q <= plain_ld_d;
      key_ld_q   <= key_ld_d;
      start_q    <= start_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-data decode for the load/run sequence.
  // NOTE: every target gets a hold (or zero-pulse) default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    plain_d    = plain_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    plain_ld_d = plain_ld_q;
    key_ld_d   = key_ld_q;
    start_d    = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd)
            CMD_PLAIN: begin
              // Fresh plaintext: drop the old contents, first beat in the LSBs;
              // later beats push it up so it ends in the MSBs.
              plain_d    = 128'(bus.din);
              plain_ld_d = 1'b0;
              cnt_d      = CNT_ONE;
              state_d    = LOAD_P;
            end
            CMD_KEY: begin
              key_d    = KEY_W'(bus.din);
              key_ld_d = 1'b0;
              cnt_d    = CNT_ONE;
              state_d  = LOAD_K;
            end
            CMD_START: begin
              if (plain_ld_q && key_ld_q) begin
                start_d = 1'b1;
                state_d = RUN;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_NOP: ;
            default: ;
          endcase
        end
      end

      LOAD_P: begin
        if (accept) begin
          if (cmd == CMD_PLAIN) begin
            plain_d = {plain_q[127-DIN_W:0], bus.din};
            if (cnt_q == P_LAST) begin
              cnt_d      = '0;
              plain_ld_d = 1'b1;
              state_d    = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            // Conflicting beat: throw away the partial plaintext and the beat.
            plain_d    = '0;
            plain_ld_d = 1'b0;
            cnt_d      = '0;
            err_d      = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      LOAD_K: begin
        if (accept) begin
          if (cmd == CMD_KEY) begin
            key_d = {key_q[KEY_W-DIN_W-1:0], bus.din};
            if (cnt_q == K_LAST) begin
              cnt_d    = '0;
              key_ld_d = 1'b1;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            key_d    = '0;
            key_ld_d = 1'b0;
            cnt_d    = '0;
            err_d    = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      RUN: begin
        // Registers are frozen while the engine works; engine_done releases
        // them, including a done that coincides with the start pulse.
        if (engine_done) begin
          plain_d    = '0;
          plain_ld_d = 1'b0;
          if (KEEP_KEY == 0) begin
            key_d    = '0;
            key_ld_d = 1'b0;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ready    = ready;
  assign engine_start = start_q;
  assign err          = err_q;
  assign plain_out    = plain_q;
  assign key_out      = key_q;
  assign loaded       = {key_ld_q, plain_ld_q};

endmodule

// File: tb/tb_aes_load_interface.sv
// Self-checking bench for aes_load_interface.
// dut_a (8-bit beats, 128-bit key, key cleared on done) runs directed
// scenarios plus randomized traffic against a beat-list reference model.
// dut_b (32-bit beats, 256-bit key, key kept on done) runs directed scenarios.
module tb_aes_load_interface;

  localparam int A_PBEATS = 128 / 8;
  localparam int A_KBEATS = 128 / 8;

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  aes_load_interface_if #(.DIN_W(8)) bus_a ();
  logic         done_a, start_a, err_a;
  logic [127:0] plain_a, key_a;
  logic [1:0]   loaded_a;

  aes_load_interface #(.DIN_W(8), .KEY_W(128), .KEEP_KEY(0)) dut_a (
    .clk          (clk),
    .rst_         (rst_),
    .bus          (bus_a),
    .engine_done  (done_a),
    .engine_start (start_a),
    .plain_out    (plain_a),
    .key_out      (key_a),
    .err          (err_a),
    .loaded       (loaded_a)
  );

  // ---------------- DUT B ----------------
  aes_load_interface_if #(.DIN_W(32)) bus_b ();
  logic         done_b, start_b, err_b;
  logic [127:0] plain_b;
  logic [255:0] key_b;
  logic [1:0]   loaded_b;

  aes_load_interface #(.DIN_W(32), .KEY_W(256), .KEEP_KEY(1)) dut_b (
    .clk          (clk),
    .rst_         (rst_),
    .bus          (bus_b),
    .engine_done  (done_b),
    .engine_start (start_b),
    .plain_out    (plain_b),
    .key_out      (key_b),
    .err          (err_b),
    .loaded       (loaded_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model for DUT A ----------------
  // The model keeps the beats of each register as a list; the register value
  // is those beats concatenated in arrival order (last beat in the LSBs).
  typedef enum int {M_IDLE, M_PLAIN, M_KEY, M_RUN} mode_e;
  mode_e      m_mode;
  logic [7:0] m_pq[$];
  logic [7:0] m_kq[$];
  bit         m_pl, m_kl, m_start, m_err;

  function automatic logic [127:0] plain_value();
    logic [127:0] v = '0;
    foreach (m_pq[i]) v = (v << 8) | 128'(m_pq[i]);
    return v;
  endfunction

  function automatic logic [127:0] key_value();
    logic [127:0] v = '0;
    foreach (m_kq[i]) v = (v << 8) | 128'(m_kq[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pq.delete();
    m_kq.delete();
    m_pl = 0; m_kl = 0; m_start = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] c, input logic [7:0] d, input bit ed);
    m_start = 0;
    m_err   = 0;
    if (m_mode == M_RUN) begin
      if (ed) begin
        m_pq.delete(); m_pl = 0;
        m_kq.delete(); m_kl = 0;
        m_mode = M_IDLE;
      end
    end else if (v) begin
      case (m_mode)
        M_IDLE: begin
          case (c)
            2'b01: begin m_pq.delete(); m_pq.push_back(d); m_pl = 0; m_mode = M_PLAIN; end
            2'b10: begin m_kq.delete(); m_kq.push_back(d); m_kl = 0; m_mode = M_KEY; end
            2'b11: if (m_pl && m_kl) begin m_mode = M_RUN; m_start = 1; end
                   else m_err = 1;
            default: ;
          endcase
        end
        M_PLAIN: begin
          if (c == 2'b01) begin
            m_pq.push_back(d);
            if (m_pq.size() == A_PBEATS) begin m_pl = 1; m_mode = M_IDLE; end
          end else begin
            m_pq.delete(); m_pl = 0; m_err = 1; m_mode = M_IDLE;
          end
        end
        M_KEY: begin
          if (c == 2'b10) begin
            m_kq.push_back(d);
            if (m_kq.size() == A_KBEATS) begin m_kl = 1; m_mode = M_IDLE; end
          end else begin
            m_kq.delete(); m_kl = 0; m_err = 1; m_mode = M_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_a(input string tag);
    check({tag, ".ready"},  256'(bus_a.ready), 256'(m_mode != M_RUN));
    check({tag, ".plain"},  256'(plain_a),     256'(plain_value()));
    check({tag, ".key"},    256'(key_a),       256'(key_value()));
    check({tag, ".loaded"}, 256'(loaded_a),    256'({m_kl, m_pl}));
    check({tag, ".err"},    256'(err_a),       256'(m_err));
    check({tag, ".start"},  256'(start_a),     256'(m_start));
  endtask

  // One clock of DUT A: drive, step the model at the edge, compare 1ns later.
  task automatic cycle_a(input bit v, input logic [1:0] c, input logic [7:0] d, input bit ed,
                         input string tag);
    bus_a.cmd_valid = v;
    bus_a.cmd       = c;
    bus_a.din       = d;
    done_a          = ed;
    @(posedge clk);
    model_step(v, c, d, ed);
    #1;
    compare_a(tag);
  endtask

  task automatic cycle_b(input bit v, input logic [1:0] c, input logic [31:0] d, input bit ed);
    bus_b.cmd_valid = v;
    bus_b.cmd       = c;
    bus_b.din       = d;
    done_b          = ed;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp_plain_b;
  logic [255:0] exp_key_b;

  initial begin
    rst_ = 1'b0;
    bus_a.cmd_valid = 1'b0; bus_a.cmd = 2'b00; bus_a.din = '0; done_a = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd = 2'b00; bus_b.din = '0; done_b = 1'b0;
    model_reset();

    // Reset state.
    #12;
    compare_a("reset");
    check("reset.b_ready", 256'(bus_b.ready), 256'(1));
    check("reset.b_key",   256'(key_b),       256'(0));
    @(negedge clk);
    rst_ = 1'b1;

    // Full plain + key load, start, engine_done.
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 2'b01, 8'(i), 1'b0, "ld_plain");
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 2'b10, 8'(8'hF0 + i), 1'b0, "ld_key");
    check("full.plain", 256'(plain_a), 256'(128'h000102030405060708090A0B0C0D0E0F));
    check("full.key",   256'(key_a),   256'(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF));
    check("full.loaded", 256'(loaded_a), 256'(2'b11));
    cycle_a(1'b1, 2'b11, 8'h00, 1'b0, "start");
    check("start.pulse", 256'(start_a), 256'(1));
    cycle_a(1'b1, 2'b01, 8'h55, 1'b0, "run_hold");
    check("run.start_once", 256'(start_a), 256'(0));
    check("run.ready",      256'(bus_a.ready), 256'(0));
    cycle_a(1'b0, 2'b00, 8'h00, 1'b0, "run_wait");
    cycle_a(1'b0, 2'b00, 8'h00, 1'b1, "done");
    check("done.loaded", 256'(loaded_a), 256'(2'b00));

    // Five plain beats then a key beat: abort.
    for (int i = 0; i < 5; i++) cycle_a(1'b1, 2'b01, 8'(8'hA0 + i), 1'b0, "part_plain");
    cycle_a(1'b1, 2'b10, 8'h77, 1'b0, "abort");
    check("abort.err",   256'(err_a),    256'(1));
    check("abort.plain", 256'(plain_a),  256'(0));
    check("abort.key",   256'(key_a),    256'(0));
    check("abort.ready", 256'(bus_a.ready), 256'(1));

    // Start with only the key loaded.
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 2'b10, 8'($urandom), 1'b0, "key_only");
    cycle_a(1'b1, 2'b11, 8'h00, 1'b0, "start_nokey");
    check("nostart.err",    256'(err_a),    256'(1));
    check("nostart.start",  256'(start_a),  256'(0));
    check("nostart.loaded", 256'(loaded_a), 256'(2'b10));
    cycle_a(1'b0, 2'b00, 8'h00, 1'b0, "after_err");

    // Asynchronous reset in the middle of a key load.
    for (int i = 0; i < 5; i++) cycle_a(1'b1, 2'b10, 8'(8'hC0 + i), 1'b0, "key_mid");
    #2 rst_ = 1'b0;
    #1;
    model_reset();
    compare_a("async_rst");
    @(negedge clk);
    rst_ = 1'b1;
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 2'b10, 8'(8'h30 + i), 1'b0, "key_after_rst");
    check("rst.reload", 256'(key_a), 256'(128'h303132333435363738393A3B3C3D3E3F));

    // Randomized traffic, biased so loads usually complete.
    for (int n = 0; n < 3000; n++) begin
      bit         v;
      bit         ed;
      logic [1:0] c;
      int         r;
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      case (m_mode)
        M_PLAIN: c = (r < 94) ? 2'b01 : 2'($urandom);
        M_KEY:   c = (r < 94) ? 2'b10 : 2'($urandom);
        default: c = (r < 40) ? 2'b01 : (r < 75) ? 2'b10 : (r < 92) ? 2'b11 : 2'b00;
      endcase
      ed = (m_mode == M_RUN) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      cycle_a(v, c, 8'($urandom), ed, "rand");
    end
    bus_a.cmd_valid = 1'b0;
    done_a = 1'b0;

    // DUT B: eight 32-bit key beats make a 256-bit key.
    exp_key_b = '0;
    for (int k = 1; k <= 8; k++) begin
      cycle_b(1'b1, 2'b10, 32'h11111111 * k, 1'b0);
      exp_key_b = {exp_key_b[223:0], 32'h11111111 * k};
      if (k == 7) check("b.key7_loaded", 256'(loaded_b), 256'(2'b00));
    end
    check("b.key8_loaded", 256'(loaded_b), 256'(2'b10));
    check("b.key_value", key_b,
          256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);

    // Plaintext, start, and engine_done landing on the start pulse.
    exp_plain_b = '0;
    for (int k = 1; k <= 4; k++) begin
      cycle_b(1'b1, 2'b01, 32'hA0000000 + k, 1'b0);
      exp_plain_b = {exp_plain_b[95:0], 32'hA0000000 + k};
    end
    check("b.plain", 256'(plain_b), 256'(exp_plain_b));
    check("b.loaded11", 256'(loaded_b), 256'(2'b11));
    cycle_b(1'b1, 2'b11, 32'h0, 1'b0);
    check("b.start", 256'(start_b), 256'(1));
    check("b.run_ready", 256'(bus_b.ready), 256'(0));
    cycle_b(1'b0, 2'b00, 32'h0, 1'b1);
    check("b.done_loaded", 256'(loaded_b), 256'(2'b10));
    check("b.done_key",    key_b, exp_key_b);
    check("b.done_plain",  256'(plain_b), 256'(0));
    check("b.done_ready",  256'(bus_b.ready), 256'(1));
    check("b.done_start",  256'(start_b), 256'(0));

    // Restart with a fresh plaintext only.
    for (int k = 1; k <= 4; k++) cycle_b(1'b1, 2'b01, 32'($urandom), 1'b0);
    cycle_b(1'b1, 2'b11, 32'h0, 1'b0);
    check("b.restart", 256'(start_b), 256'(1));
    check("b.restart_err", 256'(err_b), 256'(0));
    cycle_b(1'b0, 2'b00, 32'h0, 1'b0);
    check("b.restart_once", 256'(start_b), 256'(0));
    cycle_b(1'b0, 2'b00, 32'h0, 1'b1);
    check("b.key_kept", key_b, exp_key_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // err and engine_start must never coincide on either instance.
  always @(negedge clk) begin
    if (rst_) begin
      if (err_a && start_a) check("a.err_start_excl", 256'(1), 256'(0));
      if (err_b && start_b) check("b.err_start_excl", 256'(1), 256'(0));
    end
  end

endmodule
